// File: rtl/merge_pkg.sv
// Shared types for the merge_sched frame accumulator scheduler.
package merge_pkg;

  localparam int MERGE_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } merge_state_e;

endpackage

// File: rtl/merge_rr_arb.sv
// Combinational round-robin picker: first requester above i_last_grant, wrapping.
module merge_rr_arb
  import merge_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_grant,
  output logic             o_any_req,
  output logic [ID_W-1:0]  o_grant
);

  logic [ID_W-1:0] idx;

  always_comb begin
    o_any_req = |i_req;
    o_grant   = i_last_grant;
    idx       = '0;
    // Scan from farthest to nearest so the nearest requester wins.
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(i_last_grant) + i) % N_REQ);
      if (i_req[idx]) o_grant = idx;
    end
  end

endmodule

// File: rtl/merge_sched.sv
// Shares one accumulator across N_REQ frame producers, granting round-robin.
// Define MERGE_SAT_EN for a saturating accumulator and the o_sum_sat output.
module merge_sched
  import merge_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = MERGE_DATA_W,
  parameter int FRAME_LEN = 8,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [ID_W-1:0]         o_grant_id,
  output logic                    o_busy,
  output logic                    o_sum_valid,
  output logic [DATA_W-1:0]       o_sum_data,
  output logic [ID_W-1:0]         o_sum_id,
`ifdef MERGE_SAT_EN
  output logic                    o_sum_sat,
`endif
  input  logic                    i_sum_ready
);

  merge_state_e      state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              any_req;
  logic [ID_W-1:0]   arb_grant;
  logic [DATA_W-1:0] beat_data;
  logic [DATA_W-1:0] acc_next;
`ifdef MERGE_SAT_EN
  logic              sat_q, sat_d;
  logic [DATA_W:0]   sum_ext;
  logic              ovf;
`endif

  merge_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .i_req        (i_req_valid),
    .i_last_grant (last_q),
    .o_any_req    (any_req),
    .o_grant      (arb_grant)
  );

  assign beat_data = i_req_data[int'(grant_q)*DATA_W +: DATA_W];

`ifdef MERGE_SAT_EN
  assign sum_ext  = {1'b0, acc_q} + {1'b0, beat_data};
  assign ovf      = sum_ext[DATA_W];
  assign acc_next = ovf ? {DATA_W{1'b1}} : sum_ext[DATA_W-1:0];
`else
  assign acc_next = acc_q + beat_data;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    o_req_ready = '0;
    o_sum_valid = 1'b0;
`ifdef MERGE_SAT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
`ifdef MERGE_SAT_EN
        sat_d = 1'b0;
`endif
        if (any_req) begin
          grant_d = arb_grant;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        o_req_ready[grant_q] = 1'b1;
        if (i_req_valid[grant_q]) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef MERGE_SAT_EN
          sat_d = sat_q | ovf;
`endif
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = OUT;
        end
      end
      OUT: begin
        o_sum_valid = 1'b1;
        if (i_sum_ready) begin
          last_d  = grant_q;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MERGE_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
`ifdef MERGE_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef MERGE_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign o_grant_id = grant_q;
  assign o_sum_id   = grant_q;
  assign o_sum_data = acc_q;
  assign o_busy     = (state_q != IDLE);
`ifdef MERGE_SAT_EN
  assign o_sum_sat  = sat_q & (state_q == OUT);
`endif

endmodule
